// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path.
// Contents: ALU control encodings, the legality check on a control code,
// and default datapath/register-index widths.
package alu_pkg;

  localparam int N_DEFAULT     = 32;
  localparam int REG_W_DEFAULT = 5;
  localparam int CTRL_W        = 3;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  function automatic logic alu_ctrl_legal(input logic [CTRL_W-1:0] ctrl);
    logic legal;
    legal = 1'b0;
    case (ctrl)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_op_fifo2.sv
// Two-entry FIFO of decoded ALU operations.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   push / pop           enqueue (caller guarantees not full) / dequeue (not empty)
//   push_*               fields of the entry being enqueued
//   upd_a, upd_b         per-slot write enables overwriting a / b with upd_data
//   slot_valid, slot_*   per-slot occupancy and stored indices for the caller's comparators
//   head_*               fields of the oldest entry
//   count                occupancy, 0..2
module alu_op_fifo2
  import alu_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [N-1:0]           push_a,
  input  logic [N-1:0]           push_b,
  input  logic [REG_W-1:0]       push_rs1,
  input  logic [REG_W-1:0]       push_rs2,
  input  logic                   push_b_imm,
  input  logic [CTRL_W-1:0]      push_ctrl,
  input  logic [REG_W-1:0]       push_rd,
  input  logic [1:0]             upd_a,
  input  logic [1:0]             upd_b,
  input  logic [N-1:0]           upd_data,
  output logic [1:0]             slot_valid,
  output logic [1:0][REG_W-1:0]  slot_rs1,
  output logic [1:0][REG_W-1:0]  slot_rs2,
  output logic [1:0]             slot_b_imm,
  output logic [N-1:0]           head_a,
  output logic [N-1:0]           head_b,
  output logic [CTRL_W-1:0]      head_ctrl,
  output logic [REG_W-1:0]       head_rd,
  output logic [1:0]             count
);

  logic [1:0][N-1:0]      mem_a;
  logic [1:0][N-1:0]      mem_b;
  logic [1:0][REG_W-1:0]  mem_rs1;
  logic [1:0][REG_W-1:0]  mem_rs2;
  logic [1:0][REG_W-1:0]  mem_rd;
  logic [1:0][CTRL_W-1:0] mem_ctrl;
  logic [1:0]             mem_b_imm;
  logic                   wr_ptr;
  logic                   rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_a     <= '0;
      mem_b     <= '0;
      mem_rs1   <= '0;
      mem_rs2   <= '0;
      mem_rd    <= '0;
      mem_ctrl  <= '0;
      mem_b_imm <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push && wr_ptr == 1'(i)) begin
          mem_a[i]     <= push_a;
          mem_b[i]     <= push_b;
          mem_rs1[i]   <= push_rs1;
          mem_rs2[i]   <= push_rs2;
          mem_rd[i]    <= push_rd;
          mem_ctrl[i]  <= push_ctrl;
          mem_b_imm[i] <= push_b_imm;
        end else if (!(pop && rd_ptr == 1'(i))) begin
          // The slot leaving this cycle keeps its pre-edge operands.
          if (upd_a[i]) mem_a[i] <= upd_data;
          if (upd_b[i]) mem_b[i] <= upd_data;
        end
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    slot_valid = 2'b00;
    case (count)
      2'd1:    slot_valid[rd_ptr] = 1'b1;
      2'd2:    slot_valid = 2'b11;
      default: slot_valid = 2'b00;
    endcase
  end

  assign slot_rs1   = mem_rs1;
  assign slot_rs2   = mem_rs2;
  assign slot_b_imm = mem_b_imm;
  assign head_a     = mem_a[rd_ptr];
  assign head_b     = mem_b[rd_ptr];
  assign head_ctrl  = mem_ctrl[rd_ptr];
  assign head_rd    = mem_rd[rd_ptr];

endmodule

// File: rtl/alu_operand_stage.sv
// Registered issue stage in front of the combinational ALU.
// Accepts decoded ops (valid/ready), selects B from register or immediate,
// bypasses write-back results into operands at accept and while buffered,
// drops illegal control codes, and presents A/B/ALUControl from registers.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready, in_*        upstream op and handshake
//   fwd_valid, fwd_rd_idx, fwd_data write-back bypass bus
//   out_valid/out_ready, out_*     registered ALU operands and destination tag
//   drop_count                     saturating count of dropped illegal ops
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_rs1_idx,
  input  logic [REG_W-1:0]  in_rs2_idx,
  input  logic [REG_W-1:0]  in_rd_idx,
  input  logic [N-1:0]      in_rs1_data,
  input  logic [N-1:0]      in_rs2_data,
  input  logic [N-1:0]      in_imm,
  input  logic              in_use_imm,
  input  logic [2:0]        in_alu_ctrl,
  input  logic              fwd_valid,
  input  logic [REG_W-1:0]  fwd_rd_idx,
  input  logic [N-1:0]      fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_a,
  output logic [N-1:0]      out_b,
  output logic [2:0]        out_alu_ctrl,
  output logic [REG_W-1:0]  out_rd_idx,
  output logic [7:0]        drop_count
);

  logic                  accept;
  logic                  legal;
  logic                  push;
  logic                  pop;
  logic [N-1:0]          a_in;
  logic [N-1:0]          b_in;
  logic [1:0]            upd_a;
  logic [1:0]            upd_b;
  logic [1:0]            slot_valid;
  logic [1:0][REG_W-1:0] slot_rs1;
  logic [1:0][REG_W-1:0] slot_rs2;
  logic [1:0]            slot_b_imm;
  logic [1:0]            count;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid & in_ready;
  assign legal     = alu_ctrl_legal(in_alu_ctrl);
  assign push      = accept & legal;
  assign pop       = out_valid & out_ready;

  always_comb begin
    a_in = in_rs1_data;
    b_in = in_rs2_data;
    if (fwd_valid && in_rs1_idx != '0 && fwd_rd_idx == in_rs1_idx)
      a_in = fwd_data;
    if (in_use_imm)
      b_in = in_imm;
    else if (fwd_valid && in_rs2_idx != '0 && fwd_rd_idx == in_rs2_idx)
      b_in = fwd_data;
  end

  always_comb begin
    upd_a = 2'b00;
    upd_b = 2'b00;
    for (int i = 0; i < 2; i++) begin
      upd_a[i] = slot_valid[i] & fwd_valid & (slot_rs1[i] != '0)
               & (slot_rs1[i] == fwd_rd_idx);
      upd_b[i] = slot_valid[i] & fwd_valid & ~slot_b_imm[i]
               & (slot_rs2[i] != '0) & (slot_rs2[i] == fwd_rd_idx);
    end
  end

  alu_op_fifo2 #(.N(N), .REG_W(REG_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .push_a     (a_in),
    .push_b     (b_in),
    .push_rs1   (in_rs1_idx),
    .push_rs2   (in_rs2_idx),
    .push_b_imm (in_use_imm),
    .push_ctrl  (in_alu_ctrl),
    .push_rd    (in_rd_idx),
    .upd_a      (upd_a),
    .upd_b      (upd_b),
    .upd_data   (fwd_data),
    .slot_valid (slot_valid),
    .slot_rs1   (slot_rs1),
    .slot_rs2   (slot_rs2),
    .slot_b_imm (slot_b_imm),
    .head_a     (out_a),
    .head_b     (out_b),
    .head_ctrl  (out_alu_ctrl),
    .head_rd    (out_rd_idx),
    .count      (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_count <= 8'd0;
    else if (accept && !legal && drop_count != 8'hFF)
      drop_count <= drop_count + 8'd1;
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd_idx;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm;
  logic [2:0]  in_alu_ctrl;
  logic        fwd_valid;
  logic [4:0]  fwd_rd_idx;
  logic [31:0] fwd_data;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [2:0]  out_alu_ctrl;
  logic [4:0]  out_rd_idx;
  logic [7:0]  drop_count;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_alu_ctrl(in_alu_ctrl),
    .fwd_valid(fwd_valid), .fwd_rd_idx(fwd_rd_idx), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_ctrl(out_alu_ctrl),
    .out_rd_idx(out_rd_idx), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic [4:0]  rs1, rs2, rd;
    logic        imm;
    logic [2:0]  ctrl;
  } op_t;

  op_t q[$];
  int  drops;
  int  n_cmp = 0;
  int  n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour of one clock edge, computed from the current inputs.
  task automatic model_edge();
    bit  acc, pop;
    op_t e;
    acc = in_valid && (q.size() < 2);
    pop = (q.size() > 0) && out_ready;
    if (fwd_valid)
      foreach (q[i]) begin
        if (q[i].rs1 != 0 && q[i].rs1 == fwd_rd_idx) q[i].a = fwd_data;
        if (!q[i].imm && q[i].rs2 != 0 && q[i].rs2 == fwd_rd_idx) q[i].b = fwd_data;
      end
    if (pop) void'(q.pop_front());
    if (acc) begin
      if (in_alu_ctrl inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd5}) begin
        e.rs1 = in_rs1_idx; e.rs2 = in_rs2_idx; e.rd = in_rd_idx;
        e.imm = in_use_imm; e.ctrl = in_alu_ctrl;
        e.a = (fwd_valid && in_rs1_idx != 0 && fwd_rd_idx == in_rs1_idx) ? fwd_data : in_rs1_data;
        if (in_use_imm) e.b = in_imm;
        else e.b = (fwd_valid && in_rs2_idx != 0 && fwd_rd_idx == in_rs2_idx) ? fwd_data : in_rs2_data;
        q.push_back(e);
      end else if (drops < 255) begin
        drops++;
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("drop_count", drop_count, drops);
    if (q.size() > 0) begin
      chk("out_a", out_a, q[0].a);
      chk("out_b", out_b, q[0].b);
      chk("out_ctrl", out_alu_ctrl, q[0].ctrl);
      chk("out_rd", out_rd_idx, q[0].rd);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive_op(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic use_imm, input logic [2:0] ctrl);
    in_valid = 1'b1; in_rs1_idx = rs1; in_rs2_idx = rs2; in_rd_idx = rd;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_use_imm = use_imm;
    in_alu_ctrl = ctrl;
  endtask

  task automatic idle();
    in_valid = 1'b0; fwd_valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
  endtask

  int pops;

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; fwd_rd_idx = '0; fwd_data = '0;
    drive_op(0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    q.delete(); drops = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_drop", drop_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single op
    out_ready = 1'b1;
    drive_op(1, 2, 3, 32'd5, 32'd3, 32'd0, 1'b0, 3'b001);
    step();
    chk("single_valid", out_valid, 1);
    chk("single_a", out_a, 32'd5);
    chk("single_b", out_b, 32'd3);
    chk("single_ctrl", out_alu_ctrl, 3'b001);
    idle();
    step();
    chk("single_empty", out_valid, 0);

    // backpressure
    out_ready = 1'b0;
    drive_op(1, 2, 4, 32'h11, 32'h12, 0, 0, 3'd0); step();
    drive_op(2, 3, 5, 32'h21, 32'h22, 0, 0, 3'd2); step();
    chk("bp_full_ready", in_ready, 0);
    drive_op(3, 1, 6, 32'h31, 32'h32, 0, 0, 3'd3); step();
    chk("bp_still_full", in_ready, 0);
    out_ready = 1'b1; step();
    idle(); step(); step(); step();
    chk("bp_drained", out_valid, 0);

    // held bypass on rs1
    out_ready = 1'b0;
    drive_op(7, 8, 1, 32'd0, 32'd4, 0, 0, 3'd0); step();
    idle(); fwd_valid = 1'b1; fwd_rd_idx = 7; fwd_data = 32'hDEAD_BEEF; step();
    chk("byp_rs1", out_a, 32'hDEAD_BEEF);
    drain();
    // rs1 = 0 never bypassed
    out_ready = 1'b0;
    drive_op(0, 8, 1, 32'd0, 32'd4, 0, 0, 3'd0); step();
    idle(); fwd_valid = 1'b1; fwd_rd_idx = 0; fwd_data = 32'hDEAD_BEEF; step();
    chk("byp_r0", out_a, 32'd0);
    drain();
    // immediate b never bypassed
    out_ready = 1'b0;
    drive_op(1, 9, 1, 32'd0, 32'd4, 32'h55, 1'b1, 3'd1); step();
    idle(); fwd_valid = 1'b1; fwd_rd_idx = 9; fwd_data = 32'hDEAD_BEEF; step();
    chk("byp_imm", out_b, 32'h55);
    drain();

    // illegal codes
    out_ready = 1'b1;
    drive_op(1, 2, 3, 1, 2, 0, 0, 3'b110); step();
    drive_op(1, 2, 3, 1, 2, 0, 0, 3'b111); step();
    idle(); step();
    chk("illegal_two", drop_count, 2);
    chk("illegal_empty", out_valid, 0);
    for (int i = 0; i < 300; i++) begin
      drive_op(1, 2, 3, 1, 2, 0, 0, (i % 2) ? 3'b100 : 3'b110);
      step();
    end
    chk("illegal_sat", drop_count, 255);
    idle(); step();

    // streaming: accept and pop together, one op per cycle
    out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 101; i++) begin
      if (i < 100) drive_op(5'(i % 4), 5'(i % 3), 5'(i), 32'(i), 32'(i * 3), 0, 0, 3'd0);
      else idle();
      if (out_valid) pops++;
      step();
    end
    chk("stream_pops", pops, 100);

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_rs1_idx  = 5'($urandom_range(0, 3));
      in_rs2_idx  = 5'($urandom_range(0, 3));
      in_rd_idx   = 5'($urandom_range(0, 31));
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      in_imm      = $urandom;
      in_use_imm  = $urandom_range(0, 1);
      in_alu_ctrl = 3'($urandom_range(0, 7));
      fwd_valid   = $urandom_range(0, 1);
      fwd_rd_idx  = 5'($urandom_range(0, 3));
      fwd_data    = $urandom;
      out_ready   = ($urandom_range(0, 9) < 6);
      step();
    end

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    drive_op(2, 3, 4, 32'hAA, 32'hBB, 0, 0, 3'd0); step(); step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    q.delete(); drops = 0;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_drop", drop_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    out_ready = 1'b1;
    drive_op(1, 2, 3, 32'h77, 32'h88, 0, 0, 3'd5); step();
    chk("mrst_first_valid", out_valid, 1);
    chk("mrst_first_a", out_a, 32'h77);
    idle(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
